// File: rtl/fx_arith_unit.sv
// Signed fixed-point arithmetic unit: ADD, SUB and MUL complete in one cycle,
// DIV iterates a restoring divider for W+FRAC cycles. Results wait in HOLD
// until the consumer takes them.
// Optional feature macro: FX_ARITH_SAT_EN (saturate overflowing results
// instead of wrapping to the low W bits).
module fx_arith_unit #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] xout_o,
    output logic         ovf_o,
    output logic         div0_o
);

    localparam int unsigned XW = 2 * W;            // widest intermediate (full product)
    localparam int unsigned NB = W + FRAC;         // dividend / quotient bits
    localparam int unsigned CW = $clog2(NB + 1);

    localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MaxNeg = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StDiv, StHold} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            div0_q, div0_d;
    logic [NB-1:0]   dvd_q, dvd_d;
    logic [NB-1:0]   quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    dvs_q, dvd_abs_unused, dvs_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Range-check a sign-extended value to W bits; returns {ovf, result}.
    function automatic logic [W:0] fit(input logic [XW-1:0] v);
        logic         ovf;
        logic [W-1:0] r;
        ovf = !((&v[XW-1:W-1]) || !(|v[XW-1:W-1]));
        r   = v[W-1:0];
`ifdef FX_ARITH_SAT_EN
        if (ovf) r = v[XW-1] ? MaxNeg : MaxPos;
`endif
        return {ovf, r};
    endfunction

    logic [XW-1:0]        a_ext, b_ext, sum, dif, mul_sh, div_mag, div_val;
    logic signed [XW-1:0] prod;
    logic [W-1:0]         a_abs, b_abs;
    logic [W:0]           rem_sh, rem_sub;
    logic                 qbit;
    logic [NB-1:0]        quo_next;

    // Datapath: one-cycle results and one restoring-division step.
    always_comb begin
        a_ext    = {{W{a_i[W-1]}}, a_i};
        b_ext    = {{W{b_i[W-1]}}, b_i};
        sum      = a_ext + b_ext;
        dif      = a_ext - b_ext;
        prod     = $signed(a_i) * $signed(b_i);
        mul_sh   = prod >>> FRAC;
        a_abs    = a_i[W-1] ? (~a_i + 1'b1) : a_i;
        b_abs    = b_i[W-1] ? (~b_i + 1'b1) : b_i;
        rem_sh   = {rem_q, dvd_q[NB-1]};
        rem_sub  = rem_sh - {1'b0, dvs_q};
        qbit     = ~rem_sub[W];
        quo_next = {quo_q[NB-2:0], qbit};
        div_mag  = XW'(quo_next);
        div_val  = neg_q ? (~div_mag + 1'b1) : div_mag;
    end

    assign dvd_abs_unused = '0;

    // Next-state logic for FSM, result registers and divider.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    div0_d  = 1'b0;
                    state_d = StHold;
                    unique case (op_i)
                        2'd0: {ovf_d, res_d} = fit(sum);
                        2'd1: {ovf_d, res_d} = fit(dif);
                        2'd2: {ovf_d, res_d} = fit(mul_sh);
                        2'd3: begin
                            if (b_i == '0) begin
                                // Divide by zero: skip iteration, clamp by dividend sign.
                                res_d  = a_i[W-1] ? MaxNeg : MaxPos;
                                ovf_d  = 1'b1;
                                div0_d = 1'b1;
                            end else begin
                                state_d = StDiv;
                                dvd_d   = NB'(a_abs) << FRAC;
                                dvs_d   = b_abs;
                                quo_d   = '0;
                                rem_d   = '0;
                                neg_d   = a_i[W-1] ^ b_i[W-1];
                                cnt_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StDiv: begin
                dvd_d = dvd_q << 1;
                quo_d = quo_next;
                rem_d = qbit ? rem_sub[W-1:0] : rem_sh[W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NB - 1)) begin
                    {ovf_d, res_d} = fit(div_val);
                    div0_d         = 1'b0;
                    state_d        = StHold;
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                    div0_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StHold);
    assign xout_o      = res_q;
    assign ovf_o       = ovf_q & out_valid_o;
    assign div0_o      = div0_q & out_valid_o;

endmodule

// File: tb/tb_fx_arith_unit.sv
// Directed self-checking bench for fx_arith_unit (W=16, FRAC=8).
module tb_fx_arith_unit;

`ifdef FX_ARITH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xout;
    logic        ovf, div0;

    int n_cmp = 0;
    int n_err = 0;

    fx_arith_unit #(.W(16), .FRAC(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .xout_o      (xout),
        .ovf_o       (ovf),
        .div0_o      (div0)
    );

    always #5 clk = ~clk;

    // Issue one request (called 1 time unit after a rising edge, unit idle) and
    // wait for the result; lat = cycles from accept edge to OUT_VALID, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output logic [15:0] r, output logic v, output logic z);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        r = xout; v = ovf; z = div0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Run a table of vectors and compare latency, result and flags.
    task automatic run_table(input string name, input int n, input logic [1:0] ops[8],
                             input logic [15:0] as[8], input logic [15:0] bs[8],
                             input logic [15:0] es[8], input logic eo[8], input logic ez[8],
                             input int el[8]);
        int lat; logic [15:0] r; logic v, z;
        for (int i = 0; i < n; i++) begin
            run_op(ops[i], as[i], bs[i], lat, r, v, z);
            n_cmp++;
            if (lat !== el[i] || r !== es[i] || v !== eo[i] || z !== ez[i]) begin
                n_err++;
                $display("FAIL %s[%0d]: got lat=%0d x=%h ovf=%b div0=%b, want lat=%0d x=%h ovf=%b div0=%b",
                         name, i, lat, r, v, z, el[i], es[i], eo[i], ez[i]);
            end
            ack();
            n_cmp++;
            if (out_valid !== 1'b0 || ovf !== 1'b0 || div0 !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s[%0d]_release: got ov=%b ovf=%b div0=%b ir=%b, want 0 0 0 1",
                         name, i, out_valid, ovf, div0, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        int lat; logic [15:0] r; logic v, z;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = '0; b = '0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || xout !== 16'h0 || ovf !== 1'b0 ||
            div0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ir=%b ov=%b x=%h ovf=%b div0=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, xout, ovf, div0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release must accept.
        run_op(2'd0, 16'h0001, 16'h0002, lat, r, v, z);
        n_cmp++;
        if (lat !== 1 || r !== 16'h0003) begin
            n_err++;
            $display("FAIL first_accept: got lat=%0d x=%h, want lat=1 x=0003", lat, r);
        end
        ack();
    endtask

    task automatic test_add_sub();
        logic [1:0] ops[8]; logic [15:0] as[8], bs[8], es[8]; logic eo[8], ez[8]; int el[8];
        ops = '{2'd0, 2'd1, 2'd0, 2'd1, 0, 0, 0, 0};
        as  = '{16'h0180, 16'h0100, 16'h7F00, 16'h8000, 0, 0, 0, 0};
        bs  = '{16'h0240, 16'h0300, 16'h0200, 16'h0001, 0, 0, 0, 0};
        es  = '{16'h03C0, 16'hFE00, SAT ? 16'h7FFF : 16'h8100, SAT ? 16'h8000 : 16'h7FFF,
                0, 0, 0, 0};
        eo  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0};
        ez  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        el  = '{1, 1, 1, 1, 0, 0, 0, 0};
        run_table("addsub", 4, ops, as, bs, es, eo, ez, el);
    endtask

    task automatic test_mul();
        logic [1:0] ops[8]; logic [15:0] as[8], bs[8], es[8]; logic eo[8], ez[8]; int el[8];
        ops = '{2'd2, 2'd2, 2'd2, 2'd2, 0, 0, 0, 0};
        as  = '{16'h0180, 16'hFF00, 16'hFFFF, 16'h4000, 0, 0, 0, 0};
        bs  = '{16'h0240, 16'h0180, 16'h0001, 16'h0400, 0, 0, 0, 0};
        // 0xFFFF*0x0001 floors to -1/256 -> 0xFFFF; 64*4 overflows.
        es  = '{16'h0360, 16'hFE80, 16'hFFFF, SAT ? 16'h7FFF : 16'h0000, 0, 0, 0, 0};
        eo  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
        ez  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        el  = '{1, 1, 1, 1, 0, 0, 0, 0};
        run_table("mul", 4, ops, as, bs, es, eo, ez, el);
    endtask

    task automatic test_div();
        logic [1:0] ops[8]; logic [15:0] as[8], bs[8], es[8]; logic eo[8], ez[8]; int el[8];
        ops = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 0, 0};
        as  = '{16'h0240, 16'hFDC0, 16'h0100, 16'h7F00, 16'hFF00, 16'h0100, 0, 0};
        bs  = '{16'h0180, 16'h0180, 16'hFD00, 16'h0080, 16'h0000, 16'h0000, 0, 0};
        // 1/-3 truncates to -85/256 = 0xFFAB; 127/0.5 = 254 overflows.
        es  = '{16'h0180, 16'hFE80, 16'hFFAB, SAT ? 16'h7FFF : 16'hFE00, 16'h8000, 16'h7FFF,
                0, 0};
        eo  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
        ez  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        el  = '{25, 25, 25, 25, 1, 1, 0, 0};
        run_table("div", 6, ops, as, bs, es, eo, ez, el);
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] r; logic v, z;
        int seen;
        run_op(2'd0, 16'h0180, 16'h0240, lat, r, v, z);
        op = 2'd1; a = 16'h1234; b = 16'h0F0F; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || xout !== 16'h03C0 || in_ready !== 1'b0 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: got ov=%b x=%h ir=%b ovf=%b, want 1 03c0 0 0",
                         i, out_valid, xout, in_ready, ovf);
            end
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ready_same_cycle: got ir=%b, want 0", in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_ack_cycle: got ir=%b ov=%b, want 0 1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_ack: got ir=%b ov=%b, want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL ignored_request: got %0d valid cycles, want 0", seen);
        end
        // Immediate re-issue after handshake.
        run_op(2'd0, 16'h0010, 16'h0020, lat, r, v, z);
        n_cmp++;
        if (lat !== 1 || r !== 16'h0030) begin
            n_err++;
            $display("FAIL reissue: got lat=%0d x=%h, want 1 0030", lat, r);
        end
        ack();
    endtask

    task automatic test_reset_mid_div();
        int lat; logic [15:0] r; logic v, z;
        int seen;
        op = 2'd3; a = 16'h0240; b = 16'h0180; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || xout !== 16'h0) begin
            n_err++;
            $display("FAIL mid_div_reset: got ir=%b ov=%b x=%h, want 1 0 0000",
                     in_ready, out_valid, xout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL no_stale_result: got %0d valid cycles, want 0", seen);
        end
        run_op(2'd0, 16'h0100, 16'h0100, lat, r, v, z);
        n_cmp++;
        if (lat !== 1 || r !== 16'h0200 || v !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_add: got lat=%0d x=%h ovf=%b, want 1 0200 0", lat, r, v);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fx_arith_unit.md
FX_ARITH_UNIT -- requirements
Module: fx_arith_unit

Interface
REQ-001 SHALL have parameter W, default 16: operand/result width in bits, two's-complement signed fixed point.
REQ-002 SHALL have parameter FRAC, default 8: fraction bits; legal range 0 <= FRAC < W.
REQ-003 SHALL have port CLK, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1: operation request.
REQ-006 SHALL have port IN_READY, output, 1: unit can accept a request.
REQ-007 SHALL have port OP, input, 2: 0=ADD, 1=SUB, 2=MUL, 3=DIV.
REQ-008 SHALL have ports A and B, input, W each: operands.
REQ-009 SHALL have port OUT_VALID, output, 1: result available.
REQ-010 SHALL have port OUT_READY, input, 1: consumer accepts result.
REQ-011 SHALL have port XOUT, output, W: result.
REQ-012 SHALL have port OVF, output, 1: result exceeded the signed W-bit range; valid with OUT_VALID.
REQ-013 SHALL have port DIV0, output, 1: DIV with B == 0; valid with OUT_VALID.

Function
REQ-014 SHALL implement FSM states IDLE, DIV, HOLD; IN_READY = 1 only in IDLE.
REQ-015 SHALL accept a request on a cycle with IN_VALID && IN_READY and latch A, B, OP.
REQ-016 ADD/SUB/MUL accepted at cycle N SHALL present OUT_VALID=1 at N+1 (IDLE -> HOLD).
REQ-017 ADD/SUB SHALL compute at W+1 bits; OVF = result outside [-2^(W-1), 2^(W-1)-1].
REQ-018 MUL SHALL form the full 2W-bit signed product, arithmetic-shift right by FRAC (floor), then range-check to W bits.
REQ-019 DIV SHALL compute (|A| << FRAC) / |B| by restoring division, one quotient bit per cycle, W+FRAC cycles in state DIV; negate when signs differ (truncate toward zero); then go to HOLD.
REQ-020 DIV accepted at N SHALL present OUT_VALID at N+1+W+FRAC.
REQ-021 DIV with B == 0 SHALL skip iteration (IDLE -> HOLD, latency 1), DIV0=1, OVF=1, XOUT = max positive if A >= 0, else max negative.
REQ-022 In HOLD, XOUT/OVF/DIV0/OUT_VALID SHALL stay stable until OUT_READY=1; that cycle returns to IDLE, and OUT_VALID deasserts next cycle.
REQ-023 IN_READY SHALL be 0 in HOLD even while OUT_READY=1 (no same-cycle re-accept); a new request is accepted no earlier than the cycle after the handshake.
REQ-024 IN_VALID in DIV or HOLD SHALL be ignored; operands are not re-sampled.
REQ-025 OVF and DIV0 SHALL read 0 whenever OUT_VALID = 0.

Reset
REQ-026 RST_N low SHALL asynchronously force IDLE, IN_READY=1, OUT_VALID=0, XOUT=0, OVF=0, DIV0=0, and clear the divider state.
REQ-027 Reset asserted mid-DIV or in HOLD SHALL discard the operation; no result appears after release.
REQ-028 The first request SHALL be accepted on the first rising edge after RST_N deasserts.

Configuration
REQ-029 Macro FX_ARITH_SAT_EN defined: an overflowing result SHALL clamp to 2^(W-1)-1 or -2^(W-1) by true sign, OVF=1.
REQ-030 Macro FX_ARITH_SAT_EN undefined: an overflowing result SHALL wrap (low W bits), OVF still =1; DIV0 results per REQ-021 unchanged.

Verification (W=16, FRAC=8)
REQ-031 ADD A=0x0180 (1.5), B=0x0240 (2.25) -> one cycle later XOUT=0x03C0, OVF=0, DIV0=0.
REQ-032 MUL 0x0180*0x0240 -> XOUT=0x0360 (3.375) at N+1; DIV 0x0240/0x0180 -> XOUT=0x0180 at N+25; DIV 0xFDC0/0x0180 -> 0xFE80.
REQ-033 ADD 0x7F00+0x0200 -> with FX_ARITH_SAT_EN XOUT=0x7FFF, OVF=1; without, XOUT=0x8100, OVF=1.
REQ-034 DIV A=0xFF00, B=0 -> XOUT=0x8000, DIV0=1, OVF=1 at N+1.
REQ-035 OUT_READY held 0 for 3 cycles after ADD -> XOUT/OUT_VALID stable, IN_READY=0, IN_VALID with new operands ignored; after handshake IN_READY=1 next cycle.
REQ-036 RST_N pulsed low at DIV iteration 10 -> OUT_VALID never asserts, IN_READY=1 immediately, following ADD 0x0100+0x0100 -> 0x0200.
